// File: rtl/mem_write_checker.sv
// mem_write_checker: compares observed data-memory stores against an ordered queue of expected stores
module mem_write_checker #(
  parameter int DEPTH = 16,
  parameter int TIMEOUT = 100,
  parameter int CW = 16,
  parameter int STRICT = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  input  logic          exp_load,
  input  logic [31:0]   exp_adr,
  input  logic [31:0]   exp_data,
  input  logic          start,
  input  logic          clear,
  output logic [AW:0]   exp_count,
  output logic          exp_full,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [31:0]   mismatch_adr,
  output logic [31:0]   mismatch_data,
  output logic [CW-1:0] match_count,
  output logic [CW-1:0] other_count,
  output logic [CW-1:0] cycles
);
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  state_t state, nxt;
  logic [31:0] adr_q [DEPTH];
  logic [31:0] dat_q [DEPTH];
  logic [AW-1:0] head, tail;
  logic wr, push, hit, miss;
  logic [CW-1:0] cyc_n;
  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction
  assign exp_full = exp_count == FULL;
  assign done = state == S_PASS || state == S_FAIL || state == S_TMO;
  assign pass = state == S_PASS;
  assign timeout = state == S_TMO;
  // next state and store classification; an unknown strobe falls to the else path and reads as no store
  always_comb begin
    wr = 1'b0;
    if (memwrite) wr = 1'b1;
    push = state == S_IDLE && exp_load && !exp_full && !clear;
    hit = state == S_RUN && wr && dataadr == adr_q[head] && writedata == dat_q[head];
    miss = state == S_RUN && wr && !hit;
    cyc_n = sat(cycles);
    nxt = state;
    if (clear) nxt = S_IDLE;
    else if (state == S_IDLE && start) nxt = (exp_count == '0 && !push) ? S_PASS : S_RUN;
    else if (state == S_RUN)
      nxt = (hit && exp_count == ONE) ? S_PASS :
            (miss && STRICT != 0) ? S_FAIL :
            (cyc_n >= TLIM) ? S_TMO : S_RUN;
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= nxt;
  // queue pointers and occupancy
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      exp_count <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      exp_count <= '0;
    end else if (push) begin
      tail <= tail + 1'b1;
      exp_count <= exp_count + 1'b1;
    end else if (hit) begin
      head <= head + 1'b1;
      exp_count <= exp_count - 1'b1;
    end
  // queue storage, written only at the tail
  always_ff @(posedge clk)
    if (push) begin
      adr_q[tail] <= exp_adr;
      dat_q[tail] <= exp_data;
    end
  // run counters and failing-store capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cycles <= '0;
      match_count <= '0;
      other_count <= '0;
      mismatch_adr <= '0;
      mismatch_data <= '0;
    end else if (clear) begin
      cycles <= '0;
      match_count <= '0;
      other_count <= '0;
      mismatch_adr <= '0;
      mismatch_data <= '0;
    end else if (state == S_RUN) begin
      cycles <= cyc_n;
      if (hit) match_count <= sat(match_count);
      if (miss && STRICT == 0) other_count <= sat(other_count);
      if (miss && STRICT != 0) begin
        mismatch_adr <= dataadr;
        mismatch_data <= writedata;
      end
    end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: lenient and strict checkers side by side against a queue-based reference model
module tb_mem_write_checker;
  logic clk = 0, reset = 1, memwrite = 0, exp_load = 0, start = 0, clear = 0;
  logic [31:0] dataadr = 0, writedata = 0, exp_adr = 0, exp_data = 0;
  logic [4:0] ec [2];
  logic ef [2], dn [2], ps [2], to [2];
  logic [31:0] ma [2], md [2];
  logic [15:0] mc [2], oc [2], cy [2];
  int total = 0, bad = 0;
  localparam int MI = 0, MR = 1, MP = 2, MF = 3, MT = 4;
  logic [63:0] mq [2][$];
  int mst [2], mmc [2], moc [2], mcy [2];
  logic [31:0] mma [2], mmd [2];

  mem_write_checker #(.STRICT(0)) u0 (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .exp_load(exp_load), .exp_adr(exp_adr), .exp_data(exp_data), .start(start), .clear(clear),
    .exp_count(ec[0]), .exp_full(ef[0]), .done(dn[0]), .pass(ps[0]), .timeout(to[0]),
    .mismatch_adr(ma[0]), .mismatch_data(md[0]), .match_count(mc[0]), .other_count(oc[0]), .cycles(cy[0])
  );
  mem_write_checker #(.STRICT(1)) u1 (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .exp_load(exp_load), .exp_adr(exp_adr), .exp_data(exp_data), .start(start), .clear(clear),
    .exp_count(ec[1]), .exp_full(ef[1]), .done(dn[1]), .pass(ps[1]), .timeout(to[1]),
    .mismatch_adr(ma[1]), .mismatch_data(md[1]), .match_count(mc[1]), .other_count(oc[1]), .cycles(cy[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  function automatic void mreset();
    for (int s = 0; s < 2; s++) begin
      mq[s].delete();
      mst[s] = MI;
      mmc[s] = 0;
      moc[s] = 0;
      mcy[s] = 0;
      mma[s] = 0;
      mmd[s] = 0;
    end
  endfunction

  // one clock edge of the expected behaviour; instance 1 is the strict one
  function automatic void mstep();
    for (int s = 0; s < 2; s++) begin
      if (clear) begin
        mq[s].delete();
        mst[s] = MI;
        mmc[s] = 0;
        moc[s] = 0;
        mcy[s] = 0;
        mma[s] = 0;
        mmd[s] = 0;
      end else if (mst[s] == MI) begin
        if (exp_load && mq[s].size() < 16) mq[s].push_back({exp_adr, exp_data});
        if (start) begin
          mst[s] = (mq[s].size() == 0) ? MP : MR;
          mcy[s] = 0;
        end
      end else if (mst[s] == MR) begin
        mcy[s] = inc(mcy[s]);
        if (memwrite === 1'b1) begin
          if ({dataadr, writedata} == mq[s][0]) begin
            void'(mq[s].pop_front());
            mmc[s] = inc(mmc[s]);
            if (mq[s].size() == 0) mst[s] = MP;
          end else if (s == 1) begin
            mst[s] = MF;
            mma[s] = dataadr;
            mmd[s] = writedata;
          end else moc[s] = inc(moc[s]);
        end
        if (mst[s] == MR && mcy[s] >= 100) mst[s] = MT;
      end
    end
  endfunction

  task automatic check_all();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%0d.exp_count", s), 32'(ec[s]), 32'(mq[s].size()));
      chk($sformatf("%0d.exp_full", s), 32'(ef[s]), 32'(mq[s].size() == 16));
      chk($sformatf("%0d.done", s), 32'(dn[s]), 32'(mst[s] >= MP));
      chk($sformatf("%0d.pass", s), 32'(ps[s]), 32'(mst[s] == MP));
      chk($sformatf("%0d.timeout", s), 32'(to[s]), 32'(mst[s] == MT));
      chk($sformatf("%0d.mismatch_adr", s), ma[s], mma[s]);
      chk($sformatf("%0d.mismatch_data", s), md[s], mmd[s]);
      chk($sformatf("%0d.match_count", s), 32'(mc[s]), 32'(mmc[s]));
      chk($sformatf("%0d.other_count", s), 32'(oc[s]), 32'(moc[s]));
      chk($sformatf("%0d.cycles", s), 32'(cy[s]), 32'(mcy[s]));
    end
  endtask

  task automatic step();
    mstep();
    @(posedge clk);
    #1;
    check_all();
    memwrite = 0;
    exp_load = 0;
    start = 0;
    clear = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    exp_load = 1;
    exp_adr = a;
    exp_data = d;
    step();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1;
    dataadr = a;
    writedata = d;
    step();
  endtask

  task automatic go();
    start = 1;
    step();
  endtask

  task automatic clr();
    clear = 1;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int n;
    mreset();
    #2 check_all();
    @(posedge clk);
    #1 check_all();
    reset = 0;
    // store at RUN cycle 10 completes the run
    load(32'h14, 21);
    go();
    idle(9);
    store(32'h14, 21);
    chk("t1.pass", 32'(ps[0]), 1);
    chk("t1.cycles", 32'(cy[0]), 10);
    chk("t1.match", 32'(mc[0]), 1);
    // wrong address: strict fails and latches the store
    clr();
    load(32'h54, 7);
    go();
    store(32'h50, 7);
    chk("t2.done", 32'(dn[1]), 1);
    chk("t2.pass", 32'(ps[1]), 0);
    chk("t2.madr", ma[1], 32'h50);
    chk("t2.mdata", md[1], 7);
    // lenient ordering: out-of-order store counted as other
    clr();
    load(32'h2c, 9);
    load(32'h0, 4);
    go();
    store(32'h0, 4);
    store(32'h2c, 9);
    store(32'h0, 4);
    chk("t3.pass", 32'(ps[0]), 1);
    chk("t3.match", 32'(mc[0]), 2);
    chk("t3.other", 32'(oc[0]), 1);
    // timeout boundary, then match on the timeout edge wins
    clr();
    load(32'hc, 32'hc);
    go();
    idle(99);
    chk("t4.early", 32'(to[0]), 0);
    idle(1);
    chk("t4.timeout", 32'(to[0]), 1);
    chk("t4.cycles", 32'(cy[0]), 100);
    clr();
    load(32'hc, 32'hc);
    go();
    idle(99);
    store(32'hc, 32'hc);
    chk("t4b.pass", 32'(ps[0]), 1);
    chk("t4b.timeout", 32'(to[0]), 0);
    // overfill
    clr();
    for (int i = 0; i < 17; i++) load(32'(i * 4), 32'(i));
    chk("t5.count", 32'(ec[0]), 16);
    chk("t5.full", 32'(ef[0]), 1);
    clr();
    chk("t5.clr", 32'(ec[0]), 0);
    // asynchronous reset mid-run, then restart from empty
    for (int i = 0; i < 3; i++) load(32'(i * 4), 32'(i + 1));
    go();
    store(32'h0, 1);
    store(32'h4, 2);
    #2 reset = 1;
    #1 mreset();
    check_all();
    chk("t6.count", 32'(ec[0]), 0);
    reset = 0;
    load(32'h40, 5);
    go();
    memwrite = 1'bx;
    step();
    store(32'h40, 5);
    chk("t6.pass", 32'(ps[0]), 1);
    // random runs
    repeat (40) begin
      clr();
      n = $urandom_range(0, 18);
      for (int i = 0; i < n; i++) begin
        exp_load = 1;
        exp_adr = 32'($urandom_range(0, 15)) << 2;
        exp_data = 32'($urandom_range(0, 3));
        if (i == n - 1 && $urandom % 2 == 1) start = 1;
        step();
      end
      if (mst[0] == MI) go();
      repeat (130) begin
        if ($urandom % 5 < 2) begin
          memwrite = 1;
          if (mq[0].size() > 0 && $urandom % 3 != 0) {dataadr, writedata} = mq[0][0];
          else begin
            dataadr = 32'($urandom_range(0, 15)) << 2;
            writedata = 32'($urandom_range(0, 3));
          end
        end
        if ($urandom % 50 == 0) memwrite = 1'bx;
        exp_load = ($urandom % 8 == 0);
        exp_adr = 32'($urandom_range(0, 15)) << 2;
        exp_data = 32'($urandom_range(0, 3));
        start = ($urandom % 8 == 0);
        clear = ($urandom % 150 == 0);
        step();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
